// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: ALU operation encodings, main-control
// classes, funct/opcode field values and the multiply/divide engine states.
package mips_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100
  } alu_oper_t;

  localparam logic [1:0] ALU_LS = 2'b00;
  localparam logic [1:0] ALU_BR = 2'b01;
  localparam logic [1:0] ALU_R  = 2'b10;
  localparam logic [1:0] ALU_I  = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_SLTI = 6'b001010;
  localparam logic [5:0] OPC_ANDI = 6'b001100;
  localparam logic [5:0] OPC_ORI  = 6'b001101;
  localparam logic [5:0] OPC_XORI = 6'b001110;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } md_state_t;

endpackage

// File: rtl/md_engine.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide on
// operand magnitudes, one bit per RUN cycle, with a sign fix-up cycle into HI/LO.
module md_engine
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       kind,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  md_state_t          state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic [WIDTH-1:0]   opb, a_raw, fix_hi, fix_lo;
  logic [WIDTH:0]     msum, shifted, diff;
  logic               is_div, neg_res, neg_a, divz;
  logic               sgn, start_divz;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  // kind[1] selects divide, kind[0] selects the unsigned variant
  assign sgn        = ~kind[0];
  assign start_divz = kind[1] && (src_b == '0);
  assign busy       = (state != MD_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MD_IDLE: if (start) state_nx = start_divz ? MD_FIX : MD_RUN;
      MD_RUN:  if (cnt == '0) state_nx = MD_FIX;
      MD_FIX:  state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, opb};
    if (is_div)
      acc_nx = {diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]};
    else
      acc_nx = {msum, acc[WIDTH-1:1]};
    prod   = neg_res ? -acc : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (divz) begin
      fix_hi = a_raw;
      fix_lo = '1;
    end else if (is_div) begin
      fix_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_a   <= 1'b0;
      divz    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == MD_FIX);
      case (state)
        MD_IDLE: begin
          if (start) begin
            acc     <= {{WIDTH{1'b0}}, mag(src_a, sgn)};
            opb     <= mag(src_b, sgn);
            a_raw   <= src_a;
            is_div  <= kind[1];
            neg_res <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_a   <= sgn & src_a[WIDTH-1];
            divz    <= start_divz;
            cnt     <= CW'(WIDTH - 1);
          end
        end
        MD_RUN: begin
          acc <= acc_nx;
          cnt <= cnt - CW'(1);
        end
        MD_FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with registered operation output and an attached
// multiply/divide unit; MD-class requests stall while the engine is busy.
module alu_ctrl_mdu
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [OP_W-1:0]  operation,
  output logic             op_valid,
  output logic             illegal,
  output logic             stall,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  alu_oper_t dec_op;
  logic      dec_ill, is_md, is_mf, accept;

  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    is_md   = 1'b0;
    is_mf   = 1'b0;
    case (alu_op)
      ALU_LS: dec_op = OP_ADD;
      ALU_BR: dec_op = OP_SUB;
      ALU_R: begin
        case (funct)
          F_ADD:  dec_op = OP_ADD;
          F_SUB:  dec_op = OP_SUB;
          F_AND:  dec_op = OP_AND;
          F_OR:   dec_op = OP_OR;
          F_XOR:  dec_op = OP_XOR;
          F_NOR:  dec_op = OP_NOR;
          F_SLT:  dec_op = OP_SLT;
          F_MFHI, F_MFLO: begin
            dec_op = OP_OR;
            is_mf  = 1'b1;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: is_md = 1'b1;
          default: dec_ill = 1'b1;
        endcase
      end
      ALU_I: begin
        case (opcode)
          OPC_ADDI: dec_op = OP_ADD;
          OPC_SLTI: dec_op = OP_SLT;
          OPC_ANDI: dec_op = OP_AND;
          OPC_ORI:  dec_op = OP_OR;
          OPC_XORI: dec_op = OP_XOR;
          default:  dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Only requests that touch HI/LO or the engine wait; plain ALU ops pass
  assign stall  = valid_in && md_busy && (is_md || is_mf);
  assign accept = valid_in && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      operation <= OP_W'(OP_ADD);
      op_valid  <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      operation <= OP_W'(dec_op);
      op_valid  <= 1'b1;
      illegal   <= dec_ill;
    end else begin
      op_valid  <= 1'b0;
      illegal   <= 1'b0;
    end
  end

  md_engine #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (accept && is_md),
    .kind  (funct[1:0]),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Scoreboard bench for alu_ctrl_mdu at WIDTH=8 and WIDTH=32: stimulus pushes
// expected decode and HI/LO results, a negedge monitor pops and compares them.
module tb_alu_ctrl_mdu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v8 = 1'b0, v32 = 1'b0;
  logic [1:0] alu_op = '0;
  logic [5:0] funct = '0, opcode = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [31:0] a32 = '0, b32 = '0;

  logic [3:0]  operation8, operation32;
  logic        op_valid8, op_valid32, illegal8, illegal32, stall8, stall32;
  logic        md_busy8, md_busy32, md_done8, md_done32;
  logic [7:0]  hi8, lo8;
  logic [31:0] hi32, lo32;

  alu_ctrl_mdu #(.WIDTH(8), .OP_W(4)) dut8 (
    .clk(clk), .rst(rst), .valid_in(v8), .alu_op(alu_op), .funct(funct), .opcode(opcode),
    .src_a(a8), .src_b(b8), .operation(operation8), .op_valid(op_valid8), .illegal(illegal8),
    .stall(stall8), .md_busy(md_busy8), .md_done(md_done8), .hi(hi8), .lo(lo8)
  );

  alu_ctrl_mdu #(.WIDTH(32), .OP_W(4)) dut32 (
    .clk(clk), .rst(rst), .valid_in(v32), .alu_op(alu_op), .funct(funct), .opcode(opcode),
    .src_a(a32), .src_b(b32), .operation(operation32), .op_valid(op_valid32), .illegal(illegal32),
    .stall(stall32), .md_busy(md_busy32), .md_done(md_done32), .hi(hi32), .lo(lo32)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct { logic [3:0] op; logic ill; int unsigned cyc; } dec_t;
  typedef struct { logic [63:0] hi; logic [63:0] lo; int unsigned cyc; } md_t;
  dec_t dq8[$], dq32[$];
  md_t  mq8[$], mq32[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Issue one request; returns the index of the accepting clock edge.
  task automatic send(input bit w32, input logic [1:0] aop, input logic [5:0] fn,
                      input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] eop, input logic eill, output int unsigned acc_cyc);
    int unsigned budget = 0;
    dec_t d;
    alu_op = aop; funct = fn; opcode = opc;
    a8 = a[7:0]; b8 = b[7:0]; a32 = a; b32 = b;
    if (w32) v32 = 1'b1; else v8 = 1'b1;
    #1;
    while ((w32 ? stall32 : stall8) && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 200) begin
      checks++;
      $display("FAIL send_timeout: stalled %0d cycles, expected acceptance", budget);
      v8 = 1'b0; v32 = 1'b0; acc_cyc = 0;
      return;
    end
    acc_cyc = cyc + 1;
    d.op = eop; d.ill = eill; d.cyc = acc_cyc;
    if (w32) dq32.push_back(d); else dq8.push_back(d);
    @(posedge clk); #1;
    v8 = 1'b0; v32 = 1'b0;
  endtask

  task automatic exp_md(input bit w32, input logic [63:0] h, input logic [63:0] l, input int unsigned c);
    md_t m;
    m.hi = h; m.lo = l; m.cyc = c;
    if (w32) mq32.push_back(m); else mq8.push_back(m);
  endtask

  always @(negedge clk) begin : monitor
    dec_t d;
    md_t m;
    if (!rst) begin
      if (op_valid8 || illegal8) begin
        if (dq8.size() == 0) begin
          checks++;
          $display("FAIL dec8_unexpected: got op %0h at cycle %0d, expected no output", operation8, cyc);
        end else begin
          d = dq8.pop_front();
          chk("dec8_op", operation8, d.op);
          chk("dec8_ill", illegal8, d.ill);
          chk("dec8_cyc", cyc, d.cyc);
        end
      end
      if (op_valid32 || illegal32) begin
        if (dq32.size() == 0) begin
          checks++;
          $display("FAIL dec32_unexpected: got op %0h at cycle %0d, expected no output", operation32, cyc);
        end else begin
          d = dq32.pop_front();
          chk("dec32_op", operation32, d.op);
          chk("dec32_ill", illegal32, d.ill);
          chk("dec32_cyc", cyc, d.cyc);
        end
      end
      if (md_done8) begin
        if (mq8.size() == 0) begin
          checks++;
          $display("FAIL md8_unexpected: got md_done at cycle %0d, expected none", cyc);
        end else begin
          m = mq8.pop_front();
          chk("md8_hi", hi8, m.hi);
          chk("md8_lo", lo8, m.lo);
          chk("md8_cyc", cyc, m.cyc);
        end
      end
      if (md_done32) begin
        if (mq32.size() == 0) begin
          checks++;
          $display("FAIL md32_unexpected: got md_done at cycle %0d, expected none", cyc);
        end else begin
          m = mq32.pop_front();
          chk("md32_hi", hi32, m.hi);
          chk("md32_lo", lo32, m.lo);
          chk("md32_cyc", cyc, m.cyc);
        end
      end
    end
  end

  // {alu_op, funct, opcode, expected operation, expected illegal}
  logic [18:0] vt [14] = '{
    {2'b10, 6'b100010, 6'b000000, 4'b0110, 1'b0},
    {2'b11, 6'b000000, 6'b001110, 4'b0011, 1'b0},
    {2'b10, 6'b111111, 6'b000000, 4'b0010, 1'b1},
    {2'b00, 6'b000000, 6'b000000, 4'b0010, 1'b0},
    {2'b01, 6'b000000, 6'b000000, 4'b0110, 1'b0},
    {2'b10, 6'b100100, 6'b000000, 4'b0000, 1'b0},
    {2'b10, 6'b100111, 6'b000000, 4'b1100, 1'b0},
    {2'b10, 6'b101010, 6'b000000, 4'b0111, 1'b0},
    {2'b10, 6'b100101, 6'b000000, 4'b0001, 1'b0},
    {2'b11, 6'b000000, 6'b001010, 4'b0111, 1'b0},
    {2'b11, 6'b000000, 6'b001101, 4'b0001, 1'b0},
    {2'b11, 6'b000000, 6'b000000, 4'b0010, 1'b1},
    {2'b10, 6'b100000, 6'b000000, 4'b0010, 1'b0},
    {2'b11, 6'b000000, 6'b001000, 4'b0010, 1'b0}
  };

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int unsigned e, e2;
    int nd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op8", operation8, 4'b0010);
    chk("rst_opv8", op_valid8, 1'b0);
    chk("rst_ill8", illegal8, 1'b0);
    chk("rst_busy8", md_busy8, 1'b0);
    chk("rst_done8", md_done8, 1'b0);
    chk("rst_hi8", hi8, 8'h00);
    chk("rst_lo8", lo8, 8'h00);
    chk("rst_op32", operation32, 4'b0010);
    chk("rst_busy32", md_busy32, 1'b0);
    chk("rst_hilo32", {hi32, lo32}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 14; i++)
        send(w[0], vt[i][18:17], vt[i][16:11], vt[i][10:5], 32'h0, 32'h0, vt[i][4:1], vt[i][0], e);

    // WIDTH=8 multiply, with ALU and HI/LO traffic while the engine runs
    send(0, 2'b10, 6'b011000, 6'h0, 32'hFD, 32'h05, 4'b0010, 1'b0, e);
    exp_md(0, 64'hFF, 64'hF1, e + 9);
    chk("busy8_run", md_busy8, 1'b1);
    send(0, 2'b10, 6'b100000, 6'h0, 32'h55, 32'h66, 4'b0010, 1'b0, e2);
    chk("add_no_stall", e2, e + 1);
    send(0, 2'b10, 6'b010010, 6'h0, 32'h0, 32'h0, 4'b0001, 1'b0, e2);
    chk("mflo_stall_release", e2, e + 10);

    send(0, 2'b10, 6'b011001, 6'h0, 32'hFD, 32'h05, 4'b0010, 1'b0, e);
    exp_md(0, 64'h04, 64'hF1, e + 9);
    send(0, 2'b10, 6'b011010, 6'h0, 32'hF9, 32'h02, 4'b0010, 1'b0, e);
    exp_md(0, 64'hFF, 64'hFD, e + 9);
    send(0, 2'b10, 6'b011010, 6'h0, 32'h07, 32'hFE, 4'b0010, 1'b0, e);
    exp_md(0, 64'h01, 64'hFD, e + 9);
    send(0, 2'b10, 6'b011010, 6'h0, 32'hF9, 32'hFE, 4'b0010, 1'b0, e);
    exp_md(0, 64'hFF, 64'h03, e + 9);
    send(0, 2'b10, 6'b011010, 6'h0, 32'h80, 32'hFF, 4'b0010, 1'b0, e);
    exp_md(0, 64'h00, 64'h80, e + 9);
    send(0, 2'b10, 6'b011011, 6'h0, 32'h07, 32'h00, 4'b0010, 1'b0, e);
    exp_md(0, 64'h07, 64'hFF, e + 1);
    send(0, 2'b10, 6'b011010, 6'h0, 32'hF9, 32'h00, 4'b0010, 1'b0, e);
    exp_md(0, 64'hF9, 64'hFF, e + 1);
    send(0, 2'b10, 6'b011000, 6'h0, 32'h80, 32'h80, 4'b0010, 1'b0, e);
    exp_md(0, 64'h40, 64'h00, e + 9);
    send(0, 2'b10, 6'b011011, 6'h0, 32'hF9, 32'h02, 4'b0010, 1'b0, e);
    exp_md(0, 64'h01, 64'h7C, e + 9);

    // WIDTH=32; the add after the divide changes the operand inputs mid-run
    send(1, 2'b10, 6'b011010, 6'h0, 32'hFFFFFFF9, 32'h2, 4'b0010, 1'b0, e);
    exp_md(1, 64'hFFFFFFFF, 64'hFFFFFFFD, e + 33);
    send(1, 2'b10, 6'b100000, 6'h0, 32'h0, 32'h0, 4'b0010, 1'b0, e2);
    send(1, 2'b10, 6'b011011, 6'h0, 32'h7, 32'h0, 4'b0010, 1'b0, e);
    exp_md(1, 64'h7, 64'hFFFFFFFF, e + 1);
    send(1, 2'b10, 6'b011001, 6'h0, 32'h12345678, 32'h100, 4'b0010, 1'b0, e);
    exp_md(1, 64'h12, 64'h34567800, e + 33);
    send(1, 2'b10, 6'b011000, 6'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010, 1'b0, e);
    exp_md(1, 64'h0, 64'h1, e + 33);
    send(1, 2'b10, 6'b011000, 6'h0, 32'h7FFFFFFF, 32'h80000000, 4'b0010, 1'b0, e);
    exp_md(1, 64'hC0000000, 64'h80000000, e + 33);
    repeat (40) @(posedge clk);
    #1;

    // Abort a WIDTH=8 multiply with reset in its third RUN cycle
    send(0, 2'b10, 6'b011000, 6'h0, 32'hFD, 32'h05, 4'b0010, 1'b0, e);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", md_busy8, 1'b0);
    chk("abort_hi", hi8, 8'h00);
    chk("abort_lo", lo8, 8'h00);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (md_done8) nd++;
    end
    chk("abort_no_done", nd, 0);

    repeat (3) @(posedge clk);
    chk("dq8_drained", dq8.size(), 0);
    chk("dq32_drained", dq32.size(), 0);
    chk("mq8_drained", mq8.size(), 0);
    chk("mq32_drained", mq32.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_mdu.md
ALU_CTRL_MDU -- requirements
Module: alu_ctrl_mdu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands, HI and LO (legal 8..64, even).
REQ-002 Parameter OP_W, default 4, width of the ALU operation code.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 valid_in  input  1  instruction fields and operands valid this cycle.
REQ-006 alu_op  input  2  main-control class: 00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-007 funct / opcode  input  6 / 6  instruction funct and opcode fields.
REQ-008 src_a / src_b  input  WIDTH / WIDTH  rs / rt operand values.
REQ-009 operation  output  OP_W  registered ALU operation code.
REQ-010 op_valid  output  1  operation holds a decoded, accepted instruction.
REQ-011 illegal  output  1  accepted instruction had no legal decode.
REQ-012 stall  output  1  combinational; request this cycle not accepted, upstream holds it.
REQ-013 md_busy  output  1  multiply/divide engine occupied.
REQ-014 md_done  output  1  one-cycle pulse; HI/LO just updated.
REQ-015 hi / lo  output  WIDTH / WIDTH  HI and LO registers.

Function
REQ-016 Encodings: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, NOR 1100.
REQ-017 alu_op 00 -> ADD; 01 -> SUB.
REQ-018 alu_op 10, funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
REQ-019 alu_op 11, opcode 001000 ADD, 001010 SLT, 001100 AND, 001101 OR, 001110 XOR.
REQ-020 Any other combination except REQ-022/023 funct values: operation=ADD, illegal=1.
REQ-021 Decode latency one cycle: accepted in cycle k -> operation/op_valid/illegal valid in k+1; cycle without acceptance -> op_valid=0, illegal=0, operation holds.
REQ-022 alu_op 10 with funct 011000 mult, 011001 multu, 011010 div, 011011 divu starts the engine; operation=ADD, op_valid=1.
REQ-023 funct 010000 mfhi / 010010 mflo: operation=OR (rs=$0 path), op_valid=1; hi/lo outputs carry the value.
REQ-024 stall=1 when valid_in=1, md_busy=1 and instruction is mult/div/mfhi/mflo; else stall=0.
REQ-025 Engine FSM: IDLE -> RUN on acceptance; RUN exactly WIDTH cycles (counter WIDTH-1 down to 0); RUN -> FIX; FIX -> IDLE.
REQ-026 md_busy=1 in RUN and FIX; accept in k -> busy k+1..k+WIDTH+1, md_done=1 and hi/lo updated in k+WIDTH+2.
REQ-027 Multiply: shift-add on operand magnitudes (signed ops) or raw values (unsigned); 2*WIDTH product, HI upper, LO lower.
REQ-028 Divide: restoring, one quotient bit per RUN cycle on magnitudes; LO=quotient, HI=remainder.
REQ-029 Signed fix in FIX: product/quotient negated when sign(a)^sign(b); remainder takes sign of dividend.
REQ-030 Signed MIN / -1: LO=MIN, HI=0, no flag.
REQ-031 Divide by zero: skips RUN, IDLE -> FIX directly; LO=all ones, HI=src_a; md_done two cycles after acceptance.
REQ-032 Operands latched at acceptance; src_a/src_b changes during RUN have no effect.
REQ-033 Non-MD instructions are accepted and decoded while engine busy.

Reset
REQ-034 rst=1 at edge: FSM IDLE, counter 0, operation=0010, op_valid=0, illegal=0, md_busy=0, md_done=0, hi=0, lo=0.
REQ-035 rst mid-operation aborts engine; HI/LO cleared, no md_done pulse; rst dominates valid_in.

Structure
REQ-036 Shared package mips_pkg holds operation encodings, alu_op class constants, funct/opcode constants and engine state enum.
REQ-037 One sub-module, md_engine (FSM, counter, shift-add/restoring datapath, HI/LO); decode and stall logic in top.

Verification
REQ-038 alu_op=10, funct=100010 -> next cycle operation=0110, op_valid=1, illegal=0.
REQ-039 alu_op=11, opcode=001110 -> operation=0011; alu_op=10, funct=111111 -> operation=0010, illegal=1.
REQ-040 WIDTH=8, mult a=0xFD(-3), b=0x05 -> md_done at k+10, hi=0xFF, lo=0xF1; multu same -> hi=0x04, lo=0xF1.
REQ-041 WIDTH=32, div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=0 -> lo=0xFFFFFFFF, hi=7, md_done at k+2.
REQ-042 mflo during RUN -> stall=1 until cycle after md_done; add during RUN -> accepted, operation=0010 next cycle.
REQ-043 rst asserted at RUN cycle 3 -> md_busy=0, hi=lo=0 next cycle, no md_done thereafter.
